// File: rtl/mem_bank_rw.sv
// Parametrised single-clock memory bank: CPU read/write port A, read-only port B,
// write-protected upper region and a clear/reset-vector sequencer.
module mem_bank_rw #(
    parameter int    DATA_W         = 8,
    parameter int    ADDR_W         = 15,
    parameter int    DEPTH          = 8192,
    parameter int    ROM_BASE       = 8192,
    parameter string MEM_INIT_FILE  = "",
    parameter int    CLEAR_ON_RESET = 1,
    parameter int    RESET_VECTOR   = 0,
    parameter int    VECTOR_ADDR    = 'h1FFC,
    parameter int    VECTOR_VAL     = 'h8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_valid,
    output logic              a_err,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_valid,
    input  logic              clear_req,
    output logic              busy
);

    // Handshake: a request is taken on any rising edge where its strobe is high
    // and busy is low; the matching valid/err pulse appears for exactly one cycle
    // after that edge. There is no back-pressure.

    localparam int RAM_TOP = (ROM_BASE < DEPTH) ? ROM_BASE : DEPTH;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit HAS_RAM = (RAM_TOP > 0);

    localparam logic [ADDR_W:0]       DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]       RAM_TOP_C  = (ADDR_W + 1)'(RAM_TOP);
    localparam logic [IDX_W-1:0]      CLR_LAST   = IDX_W'(HAS_RAM ? RAM_TOP - 1 : 0);
    localparam bit                    VEC_LO_OK  = (VECTOR_ADDR >= 0) && (VECTOR_ADDR < DEPTH);
    localparam bit                    VEC_HI_OK  = (VECTOR_ADDR >= -1) && (VECTOR_ADDR + 1 < DEPTH);
    localparam logic [IDX_W-1:0]      VEC_LO_IDX = IDX_W'(VECTOR_ADDR);
    localparam logic [IDX_W-1:0]      VEC_HI_IDX = IDX_W'(VECTOR_ADDR + 1);
    localparam logic [2*DATA_W-1:0]   VEC_BITS   = (2 * DATA_W)'(VECTOR_VAL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_VEC_LO = 2'd2,
        S_VEC_HI = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR :
                                     (RESET_VECTOR != 0)   ? S_VEC_LO : S_IDLE;
    localparam state_t CLEAR_NEXT  = (RESET_VECTOR != 0) ? S_VEC_LO : S_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [IDX_W-1:0]  clr_ptr;

    logic              a_in_range;
    logic              a_in_ram;
    logic              b_in_range;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign busy       = (state != S_IDLE);
    assign a_in_range = ({1'b0, a_addr} < DEPTH_C);
    assign a_in_ram   = ({1'b0, a_addr} < RAM_TOP_C);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_C);
    assign a_idx      = a_addr[IDX_W-1:0];
    assign b_idx      = b_addr[IDX_W-1:0];

    // Single write port: the sequencer and port A never write in the same cycle
    // because port A is locked out whenever the sequencer is active.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state)
                S_CLEAR: begin
                    mem_we    = HAS_RAM;
                    mem_waddr = clr_ptr;
                end
                S_VEC_LO: begin
                    mem_we    = VEC_LO_OK;
                    mem_waddr = VEC_LO_IDX;
                    mem_wdata = VEC_BITS[DATA_W-1:0];
                end
                S_VEC_HI: begin
                    mem_we    = VEC_HI_OK;
                    mem_waddr = VEC_HI_IDX;
                    mem_wdata = VEC_BITS[2*DATA_W-1:DATA_W];
                end
                default: begin
                    mem_we    = a_en && a_we && a_in_ram;
                    mem_waddr = a_idx;
                    mem_wdata = a_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reads sample mem with non-blocking semantics, so a same-cycle write
    // is seen only by the next read (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RESET_STATE;
            clr_ptr <= '0;
            a_rdata <= '0;
            b_rdata <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_err   <= 1'b0;
        end else begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state   <= S_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (!HAS_RAM || clr_ptr == CLR_LAST) begin
                        state <= CLEAR_NEXT;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                S_VEC_LO: state <= S_VEC_HI;
                default:  state <= S_IDLE;
            endcase

            if (!busy) begin
                if (a_en) begin
                    if (!a_we) begin
                        a_valid <= 1'b1;
                        if (a_in_range) begin
                            a_rdata <= mem[a_idx];
                        end else begin
                            a_rdata <= '0;
                            a_err   <= 1'b1;
                        end
                    end else if (!a_in_ram) begin
                        a_err <= 1'b1;
                    end
                end
                if (b_req) begin
                    b_valid <= 1'b1;
                    b_rdata <= b_in_range ? mem[b_idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_rw.sv
// Bench for mem_bank_rw: directed scenarios with literal expectations plus a
// randomized phase, all checked against a behavioural memory model.
module tb_mem_bank_rw;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 15;
    localparam int DEPTH    = 8192;
    localparam int ROM_BASE = 'h1000;
    localparam int RAM_TOP  = 'h1000;
    localparam int VEC_ADDR = 'h1FFC;
    localparam logic [15:0] VEC_VAL = 16'h8000;
    localparam int SEQ_LEN  = RAM_TOP + 2;

    logic              clk;
    logic              reset;
    logic              a_en;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_valid;
    logic              a_err;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              b_valid;
    logic              clear_req;
    logic              busy;

    mem_bank_rw #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .ROM_BASE       (ROM_BASE),
        .MEM_INIT_FILE  (""),
        .CLEAR_ON_RESET (1),
        .RESET_VECTOR   (1),
        .VECTOR_ADDR    (VEC_ADDR),
        .VECTOR_VAL     (32'h8000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_en      (a_en),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_valid   (a_valid),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .b_valid   (b_valid),
        .clear_req (clear_req),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    int                busy_left  = 0;
    bit                model_live = 0;
    logic [DATA_W-1:0] e_ard, e_brd;
    bit                e_ard_k, e_brd_k;
    bit                e_av, e_ae, e_bv;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // A started sequence leaves RAM zeroed and the vector stamped; ports are
    // locked out meanwhile, so applying the final contents at once is equivalent.
    function automatic void model_sequence();
        busy_left = SEQ_LEN;
        for (int i = 0; i < RAM_TOP; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b1;
        end
        m_mem[VEC_ADDR]     = VEC_VAL[7:0];
        m_mem[VEC_ADDR + 1] = VEC_VAL[15:8];
        m_known[VEC_ADDR]     = 1'b1;
        m_known[VEC_ADDR + 1] = 1'b1;
    endfunction

    // model update, one step per rising edge from the inputs seen there
    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            e_av = 1'b0;
            e_ae = 1'b0;
            e_bv = 1'b0;
            if (reset) begin
                e_ard = '0; e_ard_k = 1'b1;
                e_brd = '0; e_brd_k = 1'b1;
                model_sequence();
                model_live = 1'b1;
            end else if (busy_left == 0) begin
                if (a_en && !a_we) begin
                    e_av = 1'b1;
                    if (int'(a_addr) < DEPTH) begin
                        e_ard = m_mem[a_addr]; e_ard_k = m_known[a_addr];
                    end else begin
                        e_ard = '0; e_ard_k = 1'b1; e_ae = 1'b1;
                    end
                end
                if (b_req) begin
                    e_bv = 1'b1;
                    if (int'(b_addr) < DEPTH) begin
                        e_brd = m_mem[b_addr]; e_brd_k = m_known[b_addr];
                    end else begin
                        e_brd = '0; e_brd_k = 1'b1;
                    end
                end
                if (a_en && a_we) begin
                    if (int'(a_addr) < RAM_TOP) begin
                        m_mem[a_addr] = a_wdata; m_known[a_addr] = 1'b1;
                    end else begin
                        e_ae = 1'b1;
                    end
                end
                if (clear_req) model_sequence();
            end else begin
                busy_left--;
            end
        end
    end

    // compare process: every falling edge once the model has seen a reset
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("busy", busy, busy_left != 0);
                check("a_valid", a_valid, e_av);
                check("a_err", a_err, e_ae);
                check("b_valid", b_valid, e_bv);
                if (e_ard_k) check("a_rdata", a_rdata, e_ard);
                if (e_brd_k) check("b_rdata", b_rdata, e_brd);
            end
        end
    end

    // driver tasks
    function automatic logic [ADDR_W-1:0] rand_addr();
        int v;
        case ($urandom_range(0, 7))
            0, 1, 2, 3: v = $urandom_range(0, 63);
            4:          v = 'h1FF8 + $urandom_range(0, 7);
            5:          v = 'h1000 + $urandom_range(0, 15);
            6:          v = $urandom_range(DEPTH, 'h7FFF);
            default:    v = $urandom_range(0, 'h1FFF);
        endcase
        return ADDR_W'(v);
    endfunction

    task automatic idle_inputs();
        a_en = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_addr = '0; clear_req = 0;
    endtask

    task automatic rand_inputs(input int clr_odds);
        a_en      = 1'($urandom_range(0, 1));
        a_we      = 1'($urandom_range(0, 1));
        a_addr    = rand_addr();
        a_wdata   = DATA_W'($urandom_range(0, 255));
        b_req     = 1'($urandom_range(0, 1));
        b_addr    = rand_addr();
        clear_req = ($urandom_range(0, clr_odds) == 0);
    endtask

    task automatic a_read(input int addr, input int exp_lit, input string name);
        @(negedge clk);
        a_en = 1; a_we = 0; a_addr = ADDR_W'(addr);
        @(negedge clk);
        idle_inputs();
        check({name, "_valid"}, a_valid, 1);
        check(name, a_rdata, exp_lit);
    endtask

    task automatic b_read(input int addr, input int exp_lit, input string name);
        @(negedge clk);
        b_req = 1; b_addr = ADDR_W'(addr);
        @(negedge clk);
        idle_inputs();
        check({name, "_valid"}, b_valid, 1);
        check(name, b_rdata, exp_lit);
    endtask

    task automatic a_write(input int addr, input int data);
        @(negedge clk);
        a_en = 1; a_we = 1; a_addr = ADDR_W'(addr); a_wdata = DATA_W'(data);
        @(negedge clk);
        idle_inputs();
    endtask

    // counts falling edges with busy high, random strobes meanwhile
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 20000) begin
            n++;
            rand_inputs(3);
            @(negedge clk);
        end
        idle_inputs();
        if (n >= 20000) begin
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    int n;

    initial begin
        reset = 0;
        idle_inputs();
        repeat (2) @(negedge clk);

        do_reset();
        wait_busy(n);
        check("reset_busy_len", n, SEQ_LEN);
        a_read('h1FFC, 'h00, "vec_lo");
        a_read('h1FFD, 'h80, "vec_hi");
        a_read('h0123, 'h00, "ram_cleared");

        a_write('h0010, 'hA5);
        a_read('h0010, 'hA5, "a_readback");
        b_read('h0010, 'hA5, "b_readback");

        a_write('h1800, 'h55);
        a_write('h1FFC, 'h55);
        a_read('h1FFC, 'h00, "rom_protected");
        a_read('h2000, 'h00, "oob_read");

        @(negedge clk);
        a_en = 1; a_we = 1; a_addr = 'h0020; a_wdata = 'h11;
        b_req = 1; b_addr = 'h0020;
        @(negedge clk);
        idle_inputs();
        check("read_first", b_rdata, 'h00);
        b_read('h0020, 'h11, "after_write");

        @(negedge clk);
        clear_req = 1; a_en = 1; a_we = 0; a_addr = 'h0010;
        @(negedge clk);
        idle_inputs();
        check("clr_same_cycle_read", a_rdata, 'hA5);
        wait_busy(n);
        check("clear_busy_len", n, SEQ_LEN);
        a_read('h0010, 'h00, "after_clear");

        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        repeat ('h800) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        wait_busy(n);
        check("mid_clear_reset_len", n, SEQ_LEN);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rand_inputs(1500);
        end
        @(negedge clk);
        idle_inputs();
        wait_busy(n);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
